// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the sequencer state encoding, the fixed requester indices and a
// small index-to-one-hot helper used to form the completion pulse.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;
   localparam int REQ_LOAD  = 2;

   // Widest requester count the arbiter supports; sizes the one-hot helper.
   localparam int MAX_REQ = 8;

   // Converts a requester index into a one-hot vector of MAX_REQ bits.
   function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] oh;
      oh      = 8'd0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection for the memory port arbiter.
// Default build: round-robin starting one past the previous winner.
// With MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
// the previous-winner input is ignored.
module rr_pick #(
   parameter int N  = 3,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last,
   output logic [GW-1:0] winner,
   output logic          any_valid
);

   // Any pending request at all.
   always_comb begin
      any_valid = |req;
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic last_unused_s;
   assign last_unused_s = ^last;

   // Lowest set index wins; scanning downwards lets the lowest one overwrite.
   always_comb begin
      winner = {GW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         winner = req[i] ? GW'(i) : winner;
      end
   end
`else
   // Search last+1, last+2, ... mod N; scanning the distance downwards lets the
   // nearest set requester overwrite the farther ones.
   always_comb begin
      winner = last;
      for (int k = N; k >= 32'sd1; k--) begin
         winner = req[(int'(last) + k) % N] ? GW'((int'(last) + k) % N) : winner;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter for fetch, data and loader/debug ports.
// Serialises accesses: one-cycle memory command, fixed MEM_LAT wait, then a
// one-cycle ack to the winner with read data captured for reads.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (fetch always
// preferred); otherwise arbitration is round-robin. Timing is the same.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*AW-1:0]      req_addr,
   input  logic [NUM_REQ*DW-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DW-1:0]              rdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       mem_en,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_wdata,
   input  logic [DW-1:0]              mem_rdata
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MEM_LAT + 1);

   state_e             state_r;
   logic [CW-1:0]      cnt_r;
   logic [GW-1:0]      last_r;
   logic [GW-1:0]      grant_r;
   logic               lat_we_r;
   logic [NUM_REQ-1:0] ack_r;
   logic [DW-1:0]      rdata_r;
   logic               busy_r;
   logic               mem_en_r;
   logic               mem_we_r;
   logic [AW-1:0]      mem_addr_r;
   logic [DW-1:0]      mem_wdata_r;

   logic [GW-1:0]      win_s;
   logic               any_s;

   rr_pick #(
      .N  (NUM_REQ),
      .GW (GW)
   ) u_pick (
      .req       (req),
      .last      (last_r),
      .winner    (win_s),
      .any_valid (any_s)
   );

   // Access sequencer: arbitrate in IDLE, strobe the memory once, wait out the
   // read latency, then pulse ack to the latched winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CW{1'b0}};
         last_r      <= GW'(NUM_REQ - 1);
         grant_r     <= {GW{1'b0}};
         lat_we_r    <= 1'b0;
         ack_r       <= {NUM_REQ{1'b0}};
         rdata_r     <= {DW{1'b0}};
         busy_r      <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  grant_r     <= win_s;
                  lat_we_r    <= req_we[win_s];
                  mem_en_r    <= 1'b1;
                  mem_we_r    <= req_we[win_s];
                  mem_addr_r  <= req_addr[int'(win_s) * AW +: AW];
                  mem_wdata_r <= req_wdata[int'(win_s) * DW +: DW];
                  busy_r      <= 1'b1;
                  state_r     <= ST_ISSUE;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               cnt_r    <= CW'(MEM_LAT);
               state_r  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_r == CW'(1'b1)) begin
                  cnt_r <= {CW{1'b0}};
                  if (!lat_we_r) begin
                     rdata_r <= mem_rdata;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  ack_r   <= NUM_REQ'(idx_to_onehot(3'(grant_r)));
                  state_r <= ST_RESP;
               end else begin
                  cnt_r   <= cnt_r - CW'(1'b1);
               end
            end
            ST_RESP: begin
               ack_r   <= {NUM_REQ{1'b0}};
               busy_r  <= 1'b0;
               last_r  <= grant_r;
               state_r <= ST_IDLE;
            end
            default: begin
               ack_r    <= {NUM_REQ{1'b0}};
               busy_r   <= 1'b0;
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_r;
   assign rdata     = rdata_r;
   assign grant_id  = grant_r;
   assign busy      = busy_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_REQ=3, AW=8, DW=16, MEM_LAT=2).
// A transaction-level reference model predicts winner, command cycle, ack
// cycle and read data; directed scenarios are followed by random traffic.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int N   = 3;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N-1:0]      req_we = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N-1:0]      ack;
   logic [DW-1:0]     rdata;
   logic [1:0]        grant_id;
   logic              busy;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .grant_id(grant_id),
      .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Background content of never-written memory locations.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {a, ~a};
   endfunction

   // ---------------- memory model (two-edge read latency) ----------------
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [DW-1:0] poke_data = '0;
   logic [DW-1:0] tb_mem [0:255];
   logic          tb_wr  [0:255];
   logic [DW-1:0] pipe0, pipe1;

   // Memory: write on command, read data appears two edges after the command.
   always @(posedge clk) begin
      if (poke_en) begin
         tb_mem[poke_addr] <= poke_data;
         tb_wr[poke_addr]  <= 1'b1;
      end
      if (mem_en && mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         tb_wr[mem_addr]  <= 1'b1;
      end
      pipe0 <= (tb_wr[mem_addr] === 1'b1) ? tb_mem[mem_addr] : pat(mem_addr);
      pipe1 <= pipe0;
   end
   assign mem_rdata = pipe1;

   // ---------------- reference model (transaction level) ----------------
   function automatic int rr_model(input logic [N-1:0] r, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
      return 0;
   endfunction

   logic [DW-1:0] ref_mem [0:255];
   logic          ref_wr  [0:255];
   int            n, t_e0, t_win, m_last, exp_gid, pick;
   logic          tx_valid, t_we;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdata, exp_rdata;

   assign pick = rr_model(req, m_last);

   // Model: one access at a time; a new one starts only LAT+3 edges after the last.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n         <= 0;
         tx_valid  <= 1'b0;
         m_last    <= N - 1;
         exp_gid   <= 0;
         exp_rdata <= '0;
      end else begin
         n <= n + 1;
         if (poke_en) begin
            ref_mem[poke_addr] <= poke_data;
            ref_wr[poke_addr]  <= 1'b1;
         end
         if (tx_valid && !t_we && (n + 1 == t_e0 + 1 + LAT)) exp_rdata <= t_rdata;
         if ((!tx_valid || (n + 1 >= t_e0 + LAT + 3)) && (req != '0)) begin
            tx_valid <= 1'b1;
            t_e0     <= n + 1;
            t_win    <= pick;
            t_we     <= req_we[pick];
            t_addr   <= req_addr[pick*AW +: AW];
            t_wdata  <= req_wdata[pick*DW +: DW];
            if (req_we[pick]) begin
               ref_mem[req_addr[pick*AW +: AW]] <= req_wdata[pick*DW +: DW];
               ref_wr[req_addr[pick*AW +: AW]]  <= 1'b1;
            end else begin
               t_rdata <= (ref_wr[req_addr[pick*AW +: AW]] === 1'b1) ?
                          ref_mem[req_addr[pick*AW +: AW]] : pat(req_addr[pick*AW +: AW]);
            end
            exp_gid <= pick;
            m_last  <= pick;
         end
      end
   end

   // ---------------- requester contract ----------------
   logic [N-1:0]    prev_req, prev_we;
   logic [N*AW-1:0] prev_addr;
   logic [N*DW-1:0] prev_wdata;

   // A requester holding req must keep its command stable.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!rst && prev_req[i] && req[i]) begin
            assert (prev_we[i] == req_we[i] &&
                    prev_addr[i*AW +: AW] == req_addr[i*AW +: AW] &&
                    prev_wdata[i*DW +: DW] == req_wdata[i*DW +: DW])
               else $error("requester %0d changed its command while requesting", i);
         end
      end
      prev_req   <= req;
      prev_we    <= req_we;
      prev_addr  <= req_addr;
      prev_wdata <= req_wdata;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic         en_e, busy_e;
      logic [N-1:0] ack_e;
      en_e   = tx_valid && (n == t_e0);
      ack_e  = (tx_valid && (n == t_e0 + 1 + LAT)) ? (3'b001 << t_win) : 3'b000;
      busy_e = tx_valid && (n >= t_e0) && (n <= t_e0 + 1 + LAT);
      chk("mem_en", mem_en, en_e);
      chk("mem_we", mem_we, en_e && t_we);
      if (en_e) begin
         chk("mem_addr", mem_addr, t_addr);
         if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
      end
      chk("ack", ack, ack_e);
      chk("busy", busy, busy_e);
      chk("grant_id", grant_id, exp_gid);
      chk("rdata", rdata, exp_rdata);
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]               = 1'b1;
      req_we[i]            = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drop(input int i);
      req[i] = 1'b0;
   endtask

   task automatic wait_ack(input int i, input int budget, output int steps);
      steps = 0;
      while (steps < budget) begin
         step();
         steps++;
         if (ack[i]) break;
      end
      chk($sformatf("ack%0d_seen", i), ack[i], 1'b1);
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 20; c++) begin
         step();
         if (!busy) break;
      end
      chk("idle_reached", busy, 1'b0);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   int       steps;
   int       order[$];
   int       exp_order[6];
   logic [N-1:0] reraise;
   int       ack1_cnt;
   logic     seen0;

   initial begin
      // 1. reset held with all requests raised
      raise(REQ_FETCH, 1'b0, 8'h01, 16'h0);
      raise(REQ_DATA,  1'b1, 8'h02, 16'h5555);
      raise(REQ_LOAD,  1'b0, 8'h03, 16'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_mem_en", mem_en, 1'b0);
         chk("rst_ack", ack, 3'b000);
      end
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
      chk("rst_grant", grant_id, 2'd0);
      chk("rst_rdata", rdata, 16'h0000);
      req = '0;
      rst = 1'b0;
      poke_en = 1'b1; poke_addr = 8'h10; poke_data = 16'hBEEF;
      step();
      poke_en = 1'b0;
      step();

      // 2. data read of 0x10
      raise(REQ_DATA, 1'b0, 8'h10, 16'h0);
      wait_ack(REQ_DATA, 20, steps);
      chk("t2_latency", steps, 4);
      chk("t2_rdata", rdata, 16'hBEEF);
      drop(REQ_DATA);
      for (int c = 0; c < 3; c++) step();
      chk("t2_rdata_held", rdata, 16'hBEEF);

      // 3. fetch-port write of 0x1234 to 0x20
      raise(REQ_FETCH, 1'b1, 8'h20, 16'h1234);
      wait_ack(REQ_FETCH, 20, steps);
      chk("t3_latency", steps, 4);
      drop(REQ_FETCH);
      chk("t3_rdata_unchanged", rdata, 16'hBEEF);
      step();
      chk("t3_mem", tb_mem[8'h20], 16'h1234);

      // 4. all three requesting, re-request after each ack (fresh pointer)
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) raise(i, 1'b0, AW'($urandom_range(0, 31)), 16'h0);
      reraise = '0;
      order.delete();
      for (int c = 0; c < 200 && order.size() < 6; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (reraise[i]) begin
               raise(i, 1'b0, AW'($urandom_range(0, 31)), 16'h0);
               reraise[i] = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               order.push_back(i);
               drop(i);
               reraise[i] = 1'b1;
            end
         end
      end
      req = '0;
      reraise = '0;
      for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_order[k] = REQ_FETCH;
`else
         exp_order[k] = k % N;
`endif
      end
      chk("t4_grants", order.size(), 6);
      for (int k = 0; k < order.size() && k < 6; k++) chk($sformatf("t4_order%0d", k), order[k], exp_order[k]);
      wait_idle();

      // 5. reset during the WAIT of a loader read
      raise(REQ_LOAD, 1'b0, 8'h30, 16'h0);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("t5_mem_en", mem_en, 1'b0);
      chk("t5_ack", ack, 3'b000);
      chk("t5_busy", busy, 1'b0);
      req = '0;
      step();
      step();
      raise(REQ_FETCH, 1'b0, 8'h50, 16'h0);
      raise(REQ_LOAD, 1'b0, 8'h30, 16'h0);
      rst = 1'b0;
      order.delete();
      for (int c = 0; c < 40 && order.size() < 2; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               order.push_back(i);
               drop(i);
            end
         end
      end
      chk("t5_grants", order.size(), 2);
      if (order.size() >= 2) begin
         chk("t5_first", order[0], REQ_FETCH);
         chk("t5_second", order[1], REQ_LOAD);
      end
      wait_idle();

      // 6. short pulse while busy is ignored; dropped winner still acked
      ack1_cnt = 0;
      seen0 = 1'b0;
      raise(REQ_FETCH, 1'b0, 8'h40, 16'h0);
      step();
      raise(REQ_DATA, 1'b0, 8'h41, 16'h0);
      step();
      drop(REQ_DATA);
      drop(REQ_FETCH);
      for (int c = 0; c < 20; c++) begin
         step();
         if (ack[REQ_FETCH]) seen0 = 1'b1;
         if (ack[REQ_DATA]) ack1_cnt++;
      end
      chk("t6_ack0_after_drop", seen0, 1'b1);
      chk("t6_no_ack1", ack1_cnt, 0);

      // 7. random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               drop(i);
            end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
               raise(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
         end
      end
      for (int c = 0; c < 30; c++) begin
         step();
         for (int i = 0; i < N; i++) if (ack[i]) drop(i);
         if (req == '0 && !busy) break;
      end
      chk("t7_drained", req, 3'b000);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
